// File: rtl/branch_issue_sched.sv
// Branch reservation queue: collapsing, oldest-first select, CDB wakeup/bypass,
// one issue per cycle to a combinational branch unit, registered resolution.
module branch_issue_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [TAG_W-1:0] alloc_rob_tag,
  input  logic [1:0]       alloc_br_type,
  input  logic [31:0]      alloc_pc,
  input  logic [31:0]      alloc_imm,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_pred_target,
  input  logic             alloc_src1_rdy,
  input  logic [TAG_W-1:0] alloc_src1_tag,
  input  logic [31:0]      alloc_src1_val,
  input  logic             alloc_src2_rdy,
  input  logic [TAG_W-1:0] alloc_src2_tag,
  input  logic [31:0]      alloc_src2_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic [1:0]       bu_br_type,
  output logic [31:0]      bu_src1,
  output logic [31:0]      bu_src2,
  output logic [31:0]      bu_pc,
  output logic [31:0]      bu_imm,
  output logic [31:0]      bu_pred_target,
  output logic             bu_pred_taken,
  input  logic             bu_mispredict,
  input  logic [31:0]      bu_redirect_pc,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_rob_tag,
  output logic             res_mispredict,
  output logic [31:0]      res_redirect_pc,
  input  logic             flush
);

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic [1:0]       br_type;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_val;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [31:0]      s2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           ent_w [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_rob_tag_q, res_rob_tag_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [31:0]      res_redirect_pc_q, res_redirect_pc_d;

  entry_t           sel_ent, alloc_ent;
  logic [DEPTH-1:0] ge_sel;
  logic             sel_found, sel_valid, kill, alloc_fire, placed;

  // Select reads only registered ready bits, so a wakeup becomes visible next cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_ent   = '0;
    ge_sel    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && vld_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel_found = 1'b1;
        sel_ent   = ent_q[i];
      end
      ge_sel[i] = sel_found;
    end
  end

  assign sel_valid   = sel_found & ~flush;
  assign kill        = sel_valid & bu_mispredict;
  assign alloc_ready = rst_n & ~vld_q[DEPTH-1] & ~flush & ~kill;
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign bu_br_type     = sel_valid ? sel_ent.br_type     : '0;
  assign bu_src1        = sel_valid ? sel_ent.s1_val      : '0;
  assign bu_src2        = sel_valid ? sel_ent.s2_val      : '0;
  assign bu_pc          = sel_valid ? sel_ent.pc          : '0;
  assign bu_imm         = sel_valid ? sel_ent.imm         : '0;
  assign bu_pred_target = sel_valid ? sel_ent.pred_target : '0;
  assign bu_pred_taken  = sel_valid & sel_ent.pred_taken;

  always_comb begin
    alloc_ent             = '0;
    alloc_ent.rob_tag     = alloc_rob_tag;
    alloc_ent.br_type     = alloc_br_type;
    alloc_ent.pc          = alloc_pc;
    alloc_ent.imm         = alloc_imm;
    alloc_ent.pred_taken  = alloc_pred_taken;
    alloc_ent.pred_target = alloc_pred_target;
    alloc_ent.s1_tag      = alloc_src1_tag;
    alloc_ent.s2_tag      = alloc_src2_tag;
    alloc_ent.s1_rdy      = alloc_src1_rdy | (cdb_valid & (cdb_tag == alloc_src1_tag));
    alloc_ent.s2_rdy      = alloc_src2_rdy | (cdb_valid & (cdb_tag == alloc_src2_tag));
    alloc_ent.s1_val      = alloc_src1_rdy ? alloc_src1_val : cdb_data;
    alloc_ent.s2_val      = alloc_src2_rdy ? alloc_src2_val : cdb_data;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_w[i] = ent_q[i];
      if (cdb_valid && !ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
        ent_w[i].s1_rdy = 1'b1;
        ent_w[i].s1_val = cdb_data;
      end
      if (cdb_valid && !ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
        ent_w[i].s2_rdy = 1'b1;
        ent_w[i].s2_val = cdb_data;
      end
    end
  end

  // Removal first (kill truncates at the issuing slot, otherwise collapse above it),
  // then allocation lands in the first slot left free.
  always_comb begin
    vld_d             = vld_q;
    placed            = 1'b0;
    res_valid_d       = sel_valid;
    res_rob_tag_d     = sel_valid ? sel_ent.rob_tag : '0;
    res_mispredict_d  = kill;
    res_redirect_pc_d = sel_valid ? bu_redirect_pc : '0;
    for (int unsigned i = 0; i < DEPTH; i++) ent_d[i] = ent_w[i];
    if (kill) begin
      vld_d = vld_q & ~ge_sel;
    end else if (sel_valid) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (ge_sel[i]) begin
          ent_d[i] = ent_w[i+1];
          vld_d[i] = vld_q[i+1];
        end
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc_fire && !placed && !vld_d[i]) begin
        ent_d[i] = alloc_ent;
        vld_d[i] = 1'b1;
        placed   = 1'b1;
      end
    end
    if (flush) begin
      vld_d             = '0;
      res_valid_d       = 1'b0;
      res_rob_tag_d     = '0;
      res_mispredict_d  = 1'b0;
      res_redirect_pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q             <= '0;
      res_valid_q       <= 1'b0;
      res_rob_tag_q     <= '0;
      res_mispredict_q  <= 1'b0;
      res_redirect_pc_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      vld_q             <= vld_d;
      res_valid_q       <= res_valid_d;
      res_rob_tag_q     <= res_rob_tag_d;
      res_mispredict_q  <= res_mispredict_d;
      res_redirect_pc_q <= res_redirect_pc_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign res_valid       = res_valid_q;
  assign res_rob_tag     = res_rob_tag_q;
  assign res_mispredict  = res_mispredict_q;
  assign res_redirect_pc = res_redirect_pc_q;

endmodule
